// File: rtl/spi_cmd_pkg.sv
// Shared constants for the SPI command decoder.
//   OP_WR / OP_RD : header opcodes in data_rx[15:12]
//   STATUS_TAG    : upper byte of the idle status word on data_tx
//   state_t       : decoder FSM states
package spi_cmd_pkg;

  localparam logic [3:0] OP_WR      = 4'hA;
  localparam logic [3:0] OP_RD      = 4'h5;
  localparam logic [7:0] STATUS_TAG = 8'hA5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    RD_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser with rising-edge detector for an asynchronous pin.
//   clk, rst : clock and synchronous active-high reset
//   din      : raw asynchronous input
//   dout     : synchronised level
//   rise     : one-cycle pulse on the first cycle dout is 1 after being 0
// All flops reset to RESET_VAL so no spurious edge follows reset.
module sync_edge_det #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  logic meta;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta   <= din;
      sync_q <= meta;
      prev_q <= sync_q;
    end
  end

  assign dout = sync_q;
  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: turns header/data words received by an SPI slave into
// register writes and reads, with an inter-word timeout and error counter.
//   clk, rst    : clock and synchronous active-high reset
//   enable      : when low the FSM, timeout counter and outputs hold
//   cs          : raw active-low SPI chip select (asynchronous)
//   data_rx     : last word received by the SPI slave
//   reg_rd_data : combinational readback of register reg_addr
//   data_tx     : word presented to the slave for the next transaction
//   reg_addr    : register address; reg_wr_data / reg_wr_en : write port
//   frame_err   : one-cycle protocol-error pulse; err_count : saturating count
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int SPI_BITS = 16,
  parameter int TIMEOUT  = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                cs,
  input  logic [SPI_BITS-1:0] data_rx,
  input  logic [SPI_BITS-1:0] reg_rd_data,
  output logic [SPI_BITS-1:0] data_tx,
  output logic [3:0]          reg_addr,
  output logic [SPI_BITS-1:0] reg_wr_data,
  output logic                reg_wr_en,
  output logic                frame_err,
  output logic [7:0]          err_count
);

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

  state_t              state;
  state_t              state_n;
  logic [15:0]         tmo_cnt;
  logic                cs_s;
  logic                word_strobe;
  logic [3:0]          opcode;
  logic                tmo_hit;
  logic                addr_load;
  logic                wr_set;
  logic                err_set;
  logic [SPI_BITS-1:0] data_tx_n;

  sync_edge_det #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (cs),
    .dout (cs_s),
    .rise (word_strobe)
  );

  assign opcode  = data_rx[15:12];
  assign tmo_hit = (tmo_cnt == TMO_LIMIT);

  // Strobe is checked before timeout so a word arriving on the timeout cycle wins.
  always_comb begin
    state_n   = state;
    addr_load = 1'b0;
    wr_set    = 1'b0;
    err_set   = 1'b0;
    if (enable) begin
      unique case (state)
        IDLE: begin
          if (word_strobe) begin
            if (opcode == OP_WR) begin
              addr_load = 1'b1;
              state_n   = WR_DATA;
            end else if (opcode == OP_RD) begin
              addr_load = 1'b1;
              state_n   = RD_RESP;
            end else begin
              err_set = 1'b1;
            end
          end
        end
        WR_DATA: begin
          if (word_strobe) begin
            wr_set  = 1'b1;
            state_n = IDLE;
          end else if (tmo_hit) begin
            err_set = 1'b1;
            state_n = IDLE;
          end
        end
        RD_RESP: begin
          if (word_strobe) begin
            state_n = IDLE;
          end else if (tmo_hit) begin
            err_set = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // data_tx only moves while chip select is deasserted so a shifting word is stable.
  always_comb begin
    data_tx_n = data_tx;
    if (enable && cs_s) begin
      if (state == RD_RESP) data_tx_n = reg_rd_data;
      else                  data_tx_n = {STATUS_TAG, err_count};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      reg_wr_en   <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= '0;
      data_tx     <= {STATUS_TAG, 8'h00};
    end else begin
      // Pulses self-clear even while disabled so they never stretch.
      reg_wr_en <= wr_set;
      frame_err <= err_set;
      data_tx   <= data_tx_n;
      if (enable) begin
        state <= state_n;
        if (state_n != state || state == IDLE) tmo_cnt <= '0;
        else                                   tmo_cnt <= tmo_cnt + 16'd1;
        if (addr_load) reg_addr    <= data_rx[11:8];
        if (wr_set)    reg_wr_data <= data_rx;
        if (err_set && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
module tb_spi_cmd_decoder;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        cs;
  logic [15:0] data_rx;
  logic [15:0] reg_rd_data;
  logic [15:0] data_tx;
  logic [3:0]  reg_addr;
  logic [15:0] reg_wr_data;
  logic        reg_wr_en;
  logic        frame_err;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;

  int          wr_pulses = 0;
  int          err_pulses = 0;
  int          wr_double = 0;
  int          err_double = 0;
  logic        wr_prev = 1'b0;
  logic        err_prev = 1'b0;
  logic [3:0]  wr_addr_seen = '0;
  logic [15:0] wr_data_seen = '0;

  int exp_wr  = 0;
  int exp_err = 0;

  spi_cmd_decoder #(.SPI_BITS(16), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .cs          (cs),
    .data_rx     (data_rx),
    .reg_rd_data (reg_rd_data),
    .data_tx     (data_tx),
    .reg_addr    (reg_addr),
    .reg_wr_data (reg_wr_data),
    .reg_wr_en   (reg_wr_en),
    .frame_err   (frame_err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  // Register file readback stub: only address 7 holds data.
  always_comb reg_rd_data = (reg_addr == 4'd7) ? 16'hBEEF : 16'h0000;

  always @(negedge clk) begin
    if (reg_wr_en) begin
      wr_pulses++;
      wr_addr_seen = reg_addr;
      wr_data_seen = reg_wr_data;
    end
    if (frame_err) err_pulses++;
    if (reg_wr_en && wr_prev) wr_double++;
    if (frame_err && err_prev) err_double++;
    wr_prev  = reg_wr_en;
    err_prev = frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One SPI word: cs low for 4 cycles, then high for 6 (strobe lands 3 edges after rise).
  task automatic send_word(input logic [15:0] w);
    @(posedge clk); #1;
    data_rx = w;
    cs = 1'b0;
    repeat (4) @(posedge clk);
    #1 cs = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b1; cs = 1'b1; data_rx = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    chk("rst_data_tx", 32'(data_tx), 32'hA500);
    chk("rst_wr_en", 32'(reg_wr_en), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_err_count", 32'(err_count), 32'h0);
    chk("rst_reg_addr", 32'(reg_addr), 32'h0);
    chk("rst_wr_data", 32'(reg_wr_data), 32'h0);

    // Write addr 3 <= 1234
    send_word(16'hA300);
    chk("wr_hdr_no_write", 32'(wr_pulses), 32'(exp_wr));
    chk("wr_hdr_addr", 32'(reg_addr), 32'h3);
    send_word(16'h1234);
    exp_wr++;
    chk("wr_pulses", 32'(wr_pulses), 32'(exp_wr));
    chk("wr_addr", 32'(wr_addr_seen), 32'h3);
    chk("wr_data", 32'(wr_data_seen), 32'h1234);
    chk("wr_no_err", 32'(err_pulses), 32'(exp_err));

    // Read addr 7
    send_word(16'h5700);
    chk("rd_addr", 32'(reg_addr), 32'h7);
    chk("rd_data_tx", 32'(data_tx), 32'hBEEF);
    send_word(16'h0000);
    chk("rd_back_status", 32'(data_tx), 32'hA500);
    chk("rd_no_err", 32'(err_pulses), 32'(exp_err));
    chk("rd_no_write", 32'(wr_pulses), 32'(exp_wr));

    // Bad opcode
    send_word(16'hF000);
    exp_err++;
    chk("bad_err_pulse", 32'(err_pulses), 32'(exp_err));
    chk("bad_err_count", 32'(err_count), 32'h1);
    chk("bad_data_tx", 32'(data_tx), 32'hA501);

    // Timeout after write header
    send_word(16'hA100);
    repeat (TMO + 5) @(posedge clk);
    #1;
    exp_err++;
    chk("tmo_err_pulse", 32'(err_pulses), 32'(exp_err));
    chk("tmo_err_count", 32'(err_count), 32'h2);
    chk("tmo_no_write", 32'(wr_pulses), 32'(exp_wr));
    // Back in IDLE: a bad word is a header error, not write data
    send_word(16'hF000);
    exp_err++;
    chk("tmo_idle_err", 32'(err_pulses), 32'(exp_err));
    chk("tmo_idle_no_write", 32'(wr_pulses), 32'(exp_wr));
    chk("tmo_idle_data_tx", 32'(data_tx), 32'hA503);

    // Data strobe on the exact timeout cycle: strobe wins
    send_word(16'hA200);
    repeat (TMO - 10) @(posedge clk);
    send_word(16'h5555);
    exp_wr++;
    chk("tie_write", 32'(wr_pulses), 32'(exp_wr));
    chk("tie_no_err", 32'(err_pulses), 32'(exp_err));
    chk("tie_wr_addr", 32'(wr_addr_seen), 32'h2);
    chk("tie_wr_data", 32'(wr_data_seen), 32'h5555);

    // Reset mid-command abandons the write
    send_word(16'hA300);
    do_reset();
    chk("midrst_err_count", 32'(err_count), 32'h0);
    chk("midrst_data_tx", 32'(data_tx), 32'hA500);
    send_word(16'h1234);
    exp_err++;
    chk("midrst_err_pulse", 32'(err_pulses), 32'(exp_err));
    chk("midrst_no_write", 32'(wr_pulses), 32'(exp_wr));
    chk("midrst_err_count1", 32'(err_count), 32'h1);

    // Disabled: strobe lost
    enable = 1'b0;
    send_word(16'hF000);
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("dis_no_err", 32'(err_pulses), 32'(exp_err));
    chk("dis_err_count", 32'(err_count), 32'h1);

    // Saturation
    for (int i = 0; i < 256; i++) send_word(16'h0F00);
    exp_err += 256;
    chk("sat_err_count", 32'(err_count), 32'hFF);
    chk("sat_err_pulses", 32'(err_pulses), 32'(exp_err));
    chk("sat_data_tx", 32'(data_tx), 32'hA5FF);

    chk("wr_never_double", 32'(wr_double), 32'h0);
    chk("err_never_double", 32'(err_double), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_cmd_decoder.md
SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 The block SHALL have parameter SPI_BITS, default 16, giving the SPI word width (fixed at 16 in this revision).
REQ-002 The block SHALL have parameter TIMEOUT, default 1000, giving the maximum clk cycles allowed between the words of one command.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; reset is rst, synchronous, active-high.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit: when low, the FSM, timeout counter and outputs hold.
REQ-006 The block SHALL have port cs, input, 1 bit: raw SPI chip select, active-low, asynchronous to clk.
REQ-007 The block SHALL have port data_rx, input, 16 bits: last received word from the SPI slave.
REQ-008 The block SHALL have port reg_rd_data, input, 16 bits: combinational readback of the register addressed by reg_addr.
REQ-009 The block SHALL have port data_tx, output, 16 bits: word loaded into the SPI slave for the next transaction.
REQ-010 The block SHALL have port reg_addr, output, 4 bits: register address for write or read.
REQ-011 The block SHALL have port reg_wr_data, output, 16 bits: register write data.
REQ-012 The block SHALL have port reg_wr_en, output, 1 bit: single-cycle write strobe.
REQ-013 The block SHALL have port frame_err, output, 1 bit: single-cycle protocol-error pulse.
REQ-014 The block SHALL have port err_count, output, 8 bits: saturating protocol-error count.

Function
REQ-015 The block SHALL synchronise cs through two flip-flops (cs_s).
REQ-016 The block SHALL assert an internal word_strobe for one cycle on the first cycle in which cs_s is 1 and was 0 in the previous cycle, i.e. 3 clk after raw cs rises.
REQ-017 On word_strobe, the block SHALL decode the current data_rx as follows: header[15:12] is the opcode (4'hA = write, 4'h5 = read), [11:8] is the address, [7:0] is ignored.
REQ-018 The FSM SHALL have states IDLE, WR_DATA and RD_RESP.
REQ-019 In IDLE, on a word_strobe carrying opcode 4'hA, the block SHALL latch reg_addr and go to WR_DATA.
REQ-020 In IDLE, on a word_strobe carrying opcode 4'h5, the block SHALL latch reg_addr, go to RD_RESP and set data_tx to reg_rd_data on the following cycle.
REQ-021 In IDLE, on a word_strobe carrying any other opcode, the block SHALL pulse frame_err and stay in IDLE.
REQ-022 In WR_DATA, on word_strobe, the block SHALL set reg_wr_data to data_rx, pulse reg_wr_en on the next cycle, and return to IDLE.
REQ-023 In RD_RESP, on word_strobe, the block SHALL return to IDLE with data_rx contents discarded; the response has been shifted out.
REQ-024 In IDLE, data_tx SHALL equal {8'hA5, err_count}, updated on the cycle after each change.
REQ-025 data_tx SHALL change only while cs_s is 1, so that the slave samples a stable word.
REQ-026 In WR_DATA and RD_RESP, a 16-bit timeout counter SHALL count enabled cycles from entry.
REQ-027 When the timeout counter reaches TIMEOUT, the block SHALL pulse frame_err and return to IDLE without writing; the counter SHALL clear on every state entry.
REQ-028 frame_err SHALL increment err_count, and err_count SHALL saturate at 8'hFF.
REQ-029 If a word_strobe and a timeout occur in the same cycle, the word_strobe SHALL take priority and the timeout SHALL be ignored.
REQ-030 While enable is low, a word_strobe SHALL be lost, with no decode and no error.
REQ-031 reg_wr_en and frame_err SHALL never be high for more than one consecutive cycle.

Reset
REQ-032 On rst, the block SHALL set state to IDLE, the synchroniser flops to 1, the timeout counter to 0, reg_addr to 0, reg_wr_data to 0, reg_wr_en to 0, frame_err to 0, err_count to 0 and data_tx to 16'hA500.
REQ-033 A reset mid-command SHALL abandon the command with no write and no error.

Structure
REQ-034 Opcode constants (OP_WR = 4'hA, OP_RD = 4'h5), the status tag 8'hA5 and the state encodings SHALL live in a shared package, spi_cmd_pkg.
REQ-035 The cs synchroniser plus edge detector SHALL be a sub-module named sync_edge_det, reusable for other pin inputs.

Verification
REQ-036 The bench SHALL cover: write header 16'hA300, then word 16'h1234 -> one-cycle reg_wr_en with reg_addr = 3 and reg_wr_data = 16'h1234.
REQ-037 The bench SHALL cover: reg_rd_data = 16'hBEEF for addr 7, then header 16'h5700 -> data_tx = 16'hBEEF before the next cs fall, then back to 16'hA5xx after that word.
REQ-038 The bench SHALL cover: header 16'hF000 -> frame_err pulse, err_count = 1, data_tx = 16'hA501.
REQ-039 The bench SHALL cover: write header, then no second word for TIMEOUT cycles -> frame_err, IDLE, no reg_wr_en.
REQ-040 The bench SHALL cover: 256 bad headers -> err_count holds at 8'hFF.
REQ-041 The bench SHALL cover: rst asserted in WR_DATA, then data word 16'h1234 -> decoded as a header, giving frame_err and no write.
